// File: rtl/matvec_pkg.sv
// Shared types, width helpers and a reference model for the streaming matrix-vector multiplier.
package matvec_pkg;

   // Largest K the reference model can hold.
   localparam int MAX_K = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_M,
      LOAD_X,
      COMP
   } state_t;

   // Width of a counter or index that must address n distinct values (never below 1 bit).
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Reference value of one output row: signed dot product of row r with x, wrapped to out_w bits.
   function automatic longint ref_row(input longint m[MAX_K*MAX_K], input longint x[MAX_K],
                                      input int k, input int r, input int out_w);
      longint s;
      longint modv;
      s = 0;
      for (int c = 0; c < k; c++) begin
         s = s + m[r*k+c] * x[c];
      end
      modv = longint'(1) << out_w;
      s = s % modv;
      if (s < 0) s = s + modv;
      if (s >= modv / 2) s = s - modv;
      return s;
   endfunction

endpackage

// File: rtl/matvec_stream_if.sv
// Valid/ready input and output streams of matvec_stream grouped into one bundle.
interface matvec_stream_if #(
   parameter int IN_W  = 14,
   parameter int OUT_W = 2*IN_W
);
   logic                    input_valid;
   logic                    input_ready;
   logic signed [IN_W-1:0]  input_data;
   logic                    new_matrix;
   logic                    output_valid;
   logic                    output_ready;
   logic signed [OUT_W-1:0] output_data;

   // The multiplier itself.
   modport slave (
      input  input_valid, input_data, new_matrix, output_ready,
      output input_ready, output_valid, output_data
   );

   // Whoever feeds elements in and drains results out.
   modport master (
      output input_valid, input_data, new_matrix, output_ready,
      input  input_ready, output_valid, output_data
   );
endinterface

// File: rtl/matvec_out_fifo.sv
// Result FIFO: lets the MAC keep going while the consumer stalls; push and pop may share a cycle.
module matvec_out_fifo
   import matvec_pkg::*;
#(
   parameter int W     = 28,
   parameter int DEPTH = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic signed [W-1:0] push_data,
   input  logic                pop,
   output logic signed [W-1:0] head,
   output logic                full,
   output logic                empty
);

   localparam int PW = cnt_w(DEPTH);
   localparam int CW = cnt_w(DEPTH + 1);

   logic signed [W-1:0] mem_q [DEPTH];
   logic signed [W-1:0] mem_d [DEPTH];
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

   // Next pointers, occupancy and storage; a pop in the same cycle makes room for a push into a full FIFO.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Register the FIFO state; reset throws away every stored result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/matvec_stream.sv
// Streaming KxK matrix-vector multiplier: loads M (optional) and x, then runs one MAC per cycle into a result FIFO.
module matvec_stream
   import matvec_pkg::*;
#(
   parameter int K         = 3,
   parameter int IN_W      = 14,
   parameter int OUT_W     = 2*IN_W,
   parameter int OUT_DEPTH = K
) (
   input  logic           clk,
   input  logic           reset,
   matvec_stream_if.slave bus
);

   localparam int NM = K*K;
   localparam int MW = cnt_w(NM);
   localparam int XW = cnt_w(K);

   state_t                   state_q, state_d;
   logic [MW-1:0]            idx_q, idx_d;
   logic [MW-1:0]            mi_q, mi_d;
   logic [XW-1:0]            c_q, c_d;
   logic signed [OUT_W-1:0]  acc_q, acc_d;
   logic                     in_ready_q, in_ready_d;
   logic signed [IN_W-1:0]   m_q [NM];
   logic signed [IN_W-1:0]   m_d [NM];
   logic signed [IN_W-1:0]   x_q [K];
   logic signed [IN_W-1:0]   x_d [K];

   logic                     accept;
   logic signed [2*IN_W-1:0] prod;
   logic signed [OUT_W-1:0]  prod_ext;
   logic signed [OUT_W-1:0]  acc_sum;
   logic                     last_col;
   logic                     fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
   logic signed [OUT_W-1:0]  fifo_head;

   assign accept   = bus.input_valid & in_ready_q;
   assign prod     = (2*IN_W)'(m_q[mi_q]) * (2*IN_W)'(x_q[c_q]);
   assign prod_ext = OUT_W'(prod);
   assign acc_sum  = acc_q + prod_ext;
   assign last_col = (c_q == XW'(K - 1));
   assign fifo_pop = ~fifo_empty & bus.output_ready;
   assign can_push = ~fifo_full | fifo_pop;

   assign bus.input_ready  = in_ready_q;
   assign bus.output_valid = ~fifo_empty;
   assign bus.output_data  = fifo_head;

   // Sequencing: IDLE/LOAD_M/LOAD_X fill the register files, COMP walks M row-major and pushes one sum per row.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mi_d      = mi_q;
      c_d       = c_q;
      acc_d     = acc_q;
      m_d       = m_q;
      x_d       = x_q;
      fifo_push = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               idx_d = MW'(1);
               if (bus.new_matrix) begin
                  m_d[0]  = bus.input_data;
                  state_d = LOAD_M;
               end else begin
                  x_d[0]  = bus.input_data;
                  state_d = LOAD_X;
               end
            end
         end
         LOAD_M: begin
            if (accept) begin
               m_d[idx_q] = bus.input_data;
               if (idx_q == MW'(NM - 1)) begin
                  idx_d   = '0;
                  state_d = LOAD_X;
               end else begin
                  idx_d = idx_q + MW'(1);
               end
            end
         end
         LOAD_X: begin
            if (accept) begin
               x_d[idx_q[XW-1:0]] = bus.input_data;
               if (idx_q == MW'(K - 1)) begin
                  idx_d   = '0;
                  mi_d    = '0;
                  c_d     = '0;
                  acc_d   = '0;
                  state_d = COMP;
               end else begin
                  idx_d = idx_q + MW'(1);
               end
            end
         end
         COMP: begin
            if (!last_col) begin
               acc_d = acc_sum;
               c_d   = c_q + XW'(1);
               mi_d  = mi_q + MW'(1);
            end else if (can_push) begin
               fifo_push = 1'b1;
               acc_d     = '0;
               c_d       = '0;
               if (mi_q == MW'(NM - 1)) begin
                  mi_d    = '0;
                  state_d = IDLE;
               end else begin
                  mi_d = mi_q + MW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d != COMP);
   end

   // FSM, counters, accumulator and register files; reset clears everything including the stored matrix.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         mi_q       <= '0;
         c_q        <= '0;
         acc_q      <= '0;
         in_ready_q <= 1'b0;
         m_q        <= '{default: '0};
         x_q        <= '{default: '0};
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mi_q       <= mi_d;
         c_q        <= c_d;
         acc_q      <= acc_d;
         in_ready_q <= in_ready_d;
         m_q        <= m_d;
         x_q        <= x_d;
      end
   end

   matvec_out_fifo #(
      .W     (OUT_W),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (acc_sum),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_matvec_stream.sv
// Directed bench for matvec_stream (K=3, IN_W=14, OUT_DEPTH=3) plus a short randomised run against the package model.
module tb_matvec_stream;
   import matvec_pkg::*;

   localparam int K         = 3;
   localparam int IN_W      = 14;
   localparam int OUT_W     = 28;
   localparam int OUT_DEPTH = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matvec_stream_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   matvec_stream #(
      .K         (K),
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .OUT_DEPTH (OUT_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int     vectors = 0;
   int     errors  = 0;
   longint exp_q[$];
   longint m_model [MAX_K*MAX_K];
   longint x_model [MAX_K];
   logic   fixed_ready = 1'b1;
   logic   rand_en = 1'b0;
   logic   rand_bit = 1'b1;

   assign bus.output_ready = rand_en ? rand_bit : fixed_ready;

   // Compare one observed value against its expected value and record the outcome.
   task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                              input logic signed [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Random consumer backpressure, refreshed just after each rising edge.
   always @(posedge clk) begin
      #1;
      rand_bit = 1'($urandom_range(0, 1));
   end

   // Every result the consumer takes must be the next expected row.
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.output_valid === 1'b1 && bus.output_ready === 1'b1) begin
         if (exp_q.size() == 0) checkOutput("unexpected_row", bus.output_valid, 0);
         else checkOutput("row", bus.output_data, exp_q.pop_front());
      end
   end

   // One input beat, held until the block accepts it; leaves at rising edge + 1.
   task automatic sendBeat(input int d, input logic nm);
      int t;
      t = 0;
      bus.input_valid = 1'b1;
      bus.input_data  = IN_W'(d);
      bus.new_matrix  = nm;
      forever begin
         @(negedge clk);
         if (bus.input_ready === 1'b1) break;
         t++;
         if (t >= 300) begin
            checkOutput("ready_timeout", t, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.input_valid = 1'b0;
      bus.input_data  = 'x;
      bus.new_matrix  = 1'bx;
   endtask

   // A whole problem: optional K*K matrix beats then K vector beats; new_matrix is randomised on non-first beats.
   task automatic applyStimulus(input logic nm, input int mv[K*K], input int xv[K], input bit gaps);
      int first;
      first = 1;
      if (nm) begin
         for (int i = 0; i < K*K; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            sendBeat(mv[i], first ? 1'b1 : 1'($urandom_range(0, 1)));
            first = 0;
            m_model[(i / K) * K + (i % K)] = longint'(mv[i]);
         end
      end
      for (int i = 0; i < K; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         sendBeat(xv[i], first ? 1'b0 : 1'($urandom_range(0, 1)));
         first = 0;
         x_model[i] = longint'(xv[i]);
      end
   endtask

   // Wait until all expected rows have been consumed, bounded by a cycle budget.
   task automatic waitDrain(input int limit);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || bus.output_valid === 1'b1) && t < limit) begin
         @(posedge clk);
         #1;
         t++;
      end
      checkOutput("rows_left", exp_q.size(), 0);
   endtask

   // Hard stop if something wedges outside the bounded waits.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int mv[K*K];
      int xv[K];
      int zm[K*K];

      for (int i = 0; i < MAX_K*MAX_K; i++) m_model[i] = 0;
      for (int i = 0; i < MAX_K; i++) x_model[i] = 0;
      for (int i = 0; i < K*K; i++) zm[i] = 0;

      reset           = 1'b1;
      bus.input_valid = 1'b0;
      bus.input_data  = '0;
      bus.new_matrix  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_input_ready", bus.input_ready, 0);
      checkOutput("rst_output_valid", bus.output_valid, 0);
      checkOutput("rst_output_data", bus.output_data, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_after_rst", bus.input_ready, 1);

      $display("[TB] basic 3x3 product");
      for (int i = 0; i < K*K; i++) mv[i] = i + 1;
      xv = '{1, 2, 3};
      exp_q.push_back(14); exp_q.push_back(32); exp_q.push_back(50);
      applyStimulus(1'b1, mv, xv, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      checkOutput("row0_not_early", bus.output_valid, 0);
      @(posedge clk); #1;
      checkOutput("row0_on_time", bus.output_valid, 1);
      repeat (5) begin @(posedge clk); #1; end
      checkOutput("ready_low_in_comp", bus.input_ready, 0);
      @(posedge clk); #1;
      checkOutput("ready_back_after_comp", bus.input_ready, 1);
      waitDrain(200);

      $display("[TB] stored matrix reused");
      xv = '{-1, 0, 1};
      exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
      applyStimulus(1'b0, zm, xv, 1'b0);
      @(negedge clk);
      checkOutput("only_three_x_beats", bus.input_ready, 0);
      waitDrain(200);

      $display("[TB] accumulator wraparound");
      for (int i = 0; i < K*K; i++) mv[i] = -8192;
      xv = '{-8192, -8192, -8192};
      repeat (3) exp_q.push_back(-67108864);
      applyStimulus(1'b1, mv, xv, 1'b0);
      waitDrain(200);

      $display("[TB] backpressure over two problems");
      fixed_ready = 1'b0;
      for (int i = 0; i < K*K; i++) mv[i] = i + 1;
      xv = '{1, 1, 1};
      exp_q.push_back(6); exp_q.push_back(15); exp_q.push_back(24);
      applyStimulus(1'b1, mv, xv, 1'b0);
      xv = '{2, 0, 1};
      exp_q.push_back(5); exp_q.push_back(14); exp_q.push_back(23);
      applyStimulus(1'b0, zm, xv, 1'b0);
      repeat (20) begin @(posedge clk); #1; end
      checkOutput("stall_input_ready", bus.input_ready, 0);
      checkOutput("stall_output_valid", bus.output_valid, 1);
      checkOutput("stall_head", bus.output_data, 6);
      repeat (20) begin @(posedge clk); #1; end
      fixed_ready = 1'b1;
      waitDrain(200);

      $display("[TB] reset during matrix load");
      fixed_ready = 1'b0;
      xv = '{1, 1, 1};
      applyStimulus(1'b0, zm, xv, 1'b0);
      for (int i = 0; i < 5; i++) sendBeat(i + 1, (i == 0) ? 1'b1 : 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_input_ready", bus.input_ready, 0);
      checkOutput("mid_rst_output_valid", bus.output_valid, 0);
      for (int i = 0; i < MAX_K*MAX_K; i++) m_model[i] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      fixed_ready = 1'b1;
      @(posedge clk); #1;
      xv = '{5, 6, 7};
      repeat (3) exp_q.push_back(0);
      applyStimulus(1'b0, zm, xv, 1'b0);
      waitDrain(200);

      $display("[TB] randomised problems");
      rand_en = 1'b1;
      for (int p = 0; p < 25; p++) begin
         logic nm;
         nm = 1'($urandom_range(0, 1));
         for (int i = 0; i < K*K; i++) mv[i] = int'($urandom_range(0, 16383)) - 8192;
         for (int i = 0; i < K; i++) xv[i] = int'($urandom_range(0, 16383)) - 8192;
         applyStimulus(nm, mv, xv, 1'b1);
         for (int r = 0; r < K; r++) exp_q.push_back(ref_row(m_model, x_model, K, r, OUT_W));
      end
      rand_en = 1'b0;
      fixed_ready = 1'b1;
      waitDrain(2000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/matvec_stream.md
# matvec_stream

Parametrised streaming matrix-vector multiplier: the K×K successor to the fixed 3×3 `matvec3_part2`. It accepts a K×K signed matrix and a K-element signed vector over one valid/ready input stream and emits the K products y = M·x over a valid/ready output stream. A stored matrix can be reused across vectors. A configurable output FIFO lets compute proceed while the consumer stalls.

## Interface
- K, 3, matrix dimension and vector length (≥2)
- IN_W, 14, signed input element width
- OUT_W, 2*IN_W, signed output width; accumulation wraps modulo 2^OUT_W
- OUT_DEPTH, K, output FIFO depth (≥1)

Ports. One clock; `reset` is asynchronous and active-high.
- clk  input  1  rising-edge clock
- reset  input  1  async active-high reset
- input_valid  input  1  input_data/new_matrix valid
- input_ready  output  1  block accepts input this cycle
- input_data  input  IN_W  signed element
- new_matrix  input  1  qualifies the first element of a problem
- output_valid  output  1  output_data valid
- output_ready  input  1  consumer accepts output
- output_data  output  OUT_W  signed result row

## Operation
- Transfer on either port happens only at a rising edge with valid&ready both high. Inputs are ignored, and may be X, when input_valid=0.
- A problem starts with its first accepted element. `new_matrix` is sampled only on that element and ignored on all others.
  - new_matrix=1: K*K matrix elements, row-major, then K vector elements.
  - new_matrix=0: K vector elements only; the stored matrix is reused.
- States:
  - IDLE: input_ready=1; first beat goes to LOAD_M if new_matrix=1, otherwise LOAD_X.
  - LOAD_M: input_ready=1; after K*K elements → LOAD_X.
  - LOAD_X: input_ready=1; after K elements → COMP.
  - COMP: input_ready=0; single MAC over rows r=0..K-1 and columns c=0..K-1; after the last row is pushed → IDLE.
- COMP arithmetic:
  - One product M[r][c]*x[c] per cycle, full 2*IN_W signed product.
  - Accumulator is OUT_W bits, two's-complement wrap, no saturation.
  - At c=K-1 the final sum is pushed into the FIFO and the accumulator clears.
- FIFO full at c=K-1 with no pop that cycle: COMP stalls, holding r, c and the accumulator. A simultaneous pop frees a slot, so the push proceeds.
- output_valid = FIFO non-empty; output_data = FIFO head. Output order equals row order, problems in order.
- The matrix store holds its contents until the next new_matrix=1 problem. It is zeroed by reset.

## Timing
- Reset values: input_ready=0 while reset is high, then 1 in IDLE from the first cycle after release. output_valid=0, output_data=0, FIFO empty, counters 0, matrix and vector zeroed.
- Last vector element accepted at edge N:
  - COMP MAC cycles run N+1 … N+K*K.
  - Row r is pushed at edge N+(r+1)*K, and output_valid rises the same cycle after that edge.
  - input_ready returns to 1 the cycle after edge N+K*K.
- Unstalled throughput: K*K+K (new matrix) or K (reused matrix) input cycles, plus K*K compute cycles per problem.
- Reset mid-operation at any point discards partial loads, the in-flight accumulator and all FIFO contents. No stale output appears after release.
- A problem that starts with new_matrix=0 after reset uses a zero matrix, so it outputs K zeros.

## Structure
- Shared package `matvec_pkg`:
  - state enum (IDLE, LOAD_M, LOAD_X, COMP)
  - clog2-based counter width helpers
  - reference-model function for benches
- Sub-module `matvec_out_fifo`: parametrised OUT_W × OUT_DEPTH synchronous FIFO with async reset. It exposes full/empty and supports push and pop in the same cycle.
- Top level contains the FSM, the matrix/vector register files and a single MAC.

## Test plan
- K=3, IN_W=14: M=1..9 row-major, x=(1,2,3), new_matrix=1 → outputs 14, 32, 50.
- Then new_matrix=0, x=(-1,0,1) → 2, 2, 2, with the matrix reused. Check that only 3 beats are accepted.
- Wraparound: all M and x = -8192 → each output is 3·2^26 mod 2^28 = -67108864.
- Backpressure: OUT_DEPTH=3, hold output_ready=0 for 60 cycles over two problems.
  - COMP stalls at c=2 with input_ready=0.
  - After release, all 6 results appear in order with none lost.
- Reset mid-load: assert reset after 5 matrix beats.
  - input_ready and output_valid drop immediately.
  - Afterwards, a new_matrix=0 problem with x=(5,6,7) yields 0, 0, 0.
- Random: K=4, IN_W=8, 10000 problems, random input_valid/output_ready with X on data when not valid, random new_matrix per problem. Compare against the `matvec_pkg` model; zero mismatches.
